// File: rtl/dds_cmd_decoder.sv
// UART command decoder for CHANNELS DDS cores: stages tuning words in per-channel
// shadow registers, commits them on SET/SET_ALL and streams the active word back LSB first.
module dds_cmd_decoder #(
  parameter int CHANNELS = 2,
  parameter int M_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         received,
  input  logic [7:0]                   rx_byte,
  input  logic                         tx_busy,
  output logic                         transmit,
  output logic [7:0]                   tx_byte,
  output logic [CHANNELS*M_WIDTH-1:0]  m,
  output logic [CHANNELS-1:0]          set,
  output logic [CHANNELS-1:0]          en,
  output logic                         err
);

  localparam int NBYTES = M_WIDTH / 8;
  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int K_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  localparam logic [4:0]       CH_LIM = 5'(CHANNELS);
  localparam logic [4:0]       NB_LIM = 5'(NBYTES);
  localparam logic [CNT_W-1:0] NB_CNT = CNT_W'(NBYTES);

  typedef enum logic [3:0] {
    OP_WRITE   = 4'h1,
    OP_SELECT  = 4'h2,
    OP_SET     = 4'h3,
    OP_ENABLE  = 4'h4,
    OP_READ    = 4'h5,
    OP_SET_ALL = 4'h6
  } op_e;

  typedef enum logic {RX_CMD, RX_DATA} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD, TX_WAIT} tx_state_e;

  typedef logic [CHANNELS-1:0][M_WIDTH-1:0] word_arr_t;

  op_e        op;
  logic [3:0] arg;

  rx_state_e           rx_state_q, rx_state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [K_W-1:0]      k_q, k_d;
  word_arr_t           shadow_q, shadow_d;
  word_arr_t           m_q, m_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] set_q, set_d;
  logic                err_q, err_d;
  logic                read_start;

  tx_state_e           tx_state_q, tx_state_d;
  logic [M_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                transmit_q, transmit_d;

  assign op  = op_e'(rx_byte[7:4]);
  assign arg = rx_byte[3:0];

  // Command decode. Data bytes only ever land in shadow, so m changes solely on SET/SET_ALL.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
    rx_state_d = rx_state_q;
    sel_d      = sel_q;
    k_d        = k_q;
    shadow_d   = shadow_q;
    m_d        = m_q;
    en_d       = en_q;
    set_d      = '0;
    err_d      = 1'b0;
    read_start = 1'b0;

    if (received) begin
      unique case (rx_state_q)
        RX_DATA: begin
          shadow_d[sel_q][{k_q, 3'b000} +: 8] = rx_byte;
          rx_state_d = RX_CMD;
        end
        RX_CMD: begin
          case (op)
            OP_WRITE: begin
              if ({1'b0, arg} < NB_LIM) begin
                k_d        = arg[K_W-1:0];
                rx_state_d = RX_DATA;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SELECT: begin
              if ({1'b0, arg} < CH_LIM) sel_d = arg[SEL_W-1:0];
              else                      err_d = 1'b1;
            end
            OP_SET: begin
              m_d[sel_q]   = shadow_q[sel_q];
              set_d[sel_q] = 1'b1;
            end
            OP_ENABLE: en_d[sel_q] = arg[0];
            OP_READ: begin
              // The tx side must be fully idle; a READ arriving as it finishes is still refused.
              if (tx_state_q == TX_IDLE) read_start = 1'b1;
              else                       err_d      = 1'b1;
            end
            OP_SET_ALL: begin
              m_d   = shadow_q;
              set_d = '1;
            end
            default: err_d = 1'b1;
          endcase
        end
      endcase
    end
  end

  // Readback: the word is snapshotted into tx_shift at READ, so later SETs do not affect the stream.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_byte_d  = tx_byte_q;
    transmit_d = 1'b0;

    unique case (tx_state_q)
      TX_IDLE: begin
        if (read_start) begin
          tx_shift_d = m_q[sel_q];
          tx_cnt_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy) begin
          tx_byte_d  = tx_shift_q[7:0];
          tx_shift_d = tx_shift_q >> 8;
          tx_cnt_d   = tx_cnt_q + 1'b1;
          transmit_d = 1'b1;
          tx_state_d = TX_GUARD;
        end
      end
      // The UART raises tx_busy a cycle after the transmit pulse, so busy is not trusted here.
      TX_GUARD: tx_state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) tx_state_d = (tx_cnt_q == NB_CNT) ? TX_IDLE : TX_SEND;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: shadow and m are register banks, but they are reset so a SET straight after reset commits zero.
      rx_state_q <= RX_CMD;
      sel_q      <= '0;
      k_q        <= '0;
      shadow_q   <= '0;
      m_q        <= '0;
      en_q       <= '0;
      set_q      <= '0;
      err_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_byte_q  <= '0;
      transmit_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      rx_state_q <= rx_state_d;
      sel_q      <= sel_d;
      k_q        <= k_d;
      shadow_q   <= shadow_d;
      m_q        <= m_d;
      en_q       <= en_d;
      set_q      <= set_d;
      err_q      <= err_d;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
    end
  end

  assign m        = m_q;
  assign set      = set_q;
  assign en       = en_q;
  assign err      = err_q;
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// Scoreboard bench for dds_cmd_decoder: stimulus queues expected set/err/transmit events,
// a monitor pops and compares them as the DUT produces them.
module tb_dds_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_busy = 1'b0;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic [63:0] m;
  logic [1:0]  set;
  logic [1:0]  en;
  logic        err;

  dds_cmd_decoder #(.CHANNELS(2), .M_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .received (received),
    .rx_byte  (rx_byte),
    .tx_busy  (tx_busy),
    .transmit (transmit),
    .tx_byte  (tx_byte),
    .m        (m),
    .set      (set),
    .en       (en),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  set;
    logic [63:0] m;
  } set_exp_t;

  set_exp_t   set_q[$];
  logic [7:0] tx_q[$];
  int         err_pending = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte  = b;
    received = 1'b1;
    @(posedge clk); #1;
    received = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h10 + i));
      send(w[8*i +: 8]);
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_tx_drain(input int limit);
    int n = 0;
    while (tx_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("tx_drain_pending", 64'(tx_q.size()), 64'd0);
  endtask

  // UART tx model: busy for 10 cycles after each transmit pulse.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (transmit) cnt = 10;
      else if (cnt > 0) cnt--;
      tx_busy = (cnt != 0);
    end
  end

  // Monitor: sampled just after each active edge.
  initial begin
    set_exp_t   e;
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (set !== 2'b00) begin
          if (set_q.size() == 0) check("set_unexpected", 64'(set), 64'd0);
          else begin
            e = set_q.pop_front();
            check("set_bits", 64'(set), 64'(e.set));
            check("set_m", m, e.m);
          end
        end
        if (err) begin
          check("err_expected", 64'(err_pending > 0), 64'd1);
          if (err_pending > 0) err_pending--;
        end
        if (transmit) begin
          check("tx_busy_at_launch", 64'(tx_busy), 64'd0);
          if (tx_q.size() == 0) check("tx_unexpected", 64'(transmit), 64'd0);
          else begin
            b = tx_q.pop_front();
            check("tx_byte", 64'(tx_byte), 64'(b));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq2[9];
    seq2 = '{8'h20, 8'h10, 8'h2A, 8'h11, 8'h67, 8'h12, 8'h02, 8'h13, 8'h00};

    pulse_rst();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("idle_after_reset", {m[58:0], en, set, transmit, err}, 64'd0);
    end

    // Build word 0x0002672A in shadow0; m must not move until SET.
    for (int i = 0; i < 9; i++) begin
      send(seq2[i]);
      check("m_before_set", m, 64'd0);
    end
    set_q.push_back('{set: 2'b01, m: 64'h00000000_0002672A});
    send(8'h30);

    // Channel 1 word and enable.
    send(8'h21);
    write_word(32'h00010000);
    set_q.push_back('{set: 2'b10, m: 64'h00010000_0002672A});
    send(8'h30);
    send(8'h41);
    check("en_after_0x41", 64'(en), 64'd2);
    send(8'h40);
    check("en_after_0x40", 64'(en), 64'd0);
    check("m1_after_0x40", 64'(m[63:32]), 64'h00010000);

    // Simultaneous update.
    send(8'h20);
    write_word(32'h11111111);
    send(8'h21);
    write_word(32'h22222222);
    set_q.push_back('{set: 2'b11, m: 64'h22222222_11111111});
    send(8'h60);

    // Readback with busy READ and a mid-stream SET.
    write_word(32'h0002672A);
    set_q.push_back('{set: 2'b10, m: 64'h0002672A_11111111});
    send(8'h30);
    tx_q.push_back(8'h2A);
    tx_q.push_back(8'h67);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    send(8'h50);
    err_pending++;
    send(8'h50);
    write_word(32'hDEADBEEF);
    set_q.push_back('{set: 2'b10, m: 64'hDEADBEEF_11111111});
    send(8'h30);
    wait_tx_drain(300);
    repeat (20) @(posedge clk);

    // Rejected bytes; the byte after a bad WRITE is a command.
    err_pending++;
    send(8'h14);
    err_pending++;
    send(8'h22);
    err_pending++;
    send(8'hF0);
    set_q.push_back('{set: 2'b10, m: 64'hDEADBEEF_11111111});
    send(8'h30);

    // Reset mid-readback: only the first byte may appear.
    tx_q.push_back(8'hEF);
    send(8'h50);
    wait_tx_drain(100);
    pulse_rst();
    check("transmit_after_rst", 64'(transmit), 64'd0);
    check("m_after_rst", m, 64'd0);
    repeat (60) @(posedge clk);

    // Reset while in DATA: the next byte must decode as a command.
    send(8'h10);
    pulse_rst();
    set_q.push_back('{set: 2'b01, m: 64'd0});
    send(8'h30);
    check("m0_after_data_rst", m, 64'd0);
    check("en_after_data_rst", 64'(en), 64'd0);
    repeat (30) @(posedge clk);
    #1;

    check("set_q_empty", 64'(set_q.size()), 64'd0);
    check("tx_q_empty", 64'(tx_q.size()), 64'd0);
    check("err_pending_zero", 64'(err_pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_cmd_decoder.md
Name: dds_cmd_decoder

Overview:
Parametrised successor to the single-channel DDS command parser. It decodes the UART byte stream into per-channel tuning words, set strobes and enables for CHANNELS DDS cores. It adds channel selection, simultaneous update of all channels and readback of the active tuning word. It sits between the UART rx/tx cores and the DDS phase accumulators.

Parameters:
CHANNELS, 2, number of DDS channels driven (1..16)
M_WIDTH, 32, tuning word width in bits; a multiple of 8, 8..128
NBYTES, M_WIDTH/8, derived local: bytes per tuning word

Ports:
clk  input  1  system clock (12 MHz)
rst  input  1  synchronous, active-high reset
received  input  1  one-cycle pulse from the UART rx core; rx_byte is valid this cycle
rx_byte  input  8  received byte
tx_busy  input  1  high while the UART tx core is sending
transmit  output  1  one-cycle pulse requesting transmission of tx_byte
tx_byte  output  8  byte to transmit; held stable from the transmit pulse until the next pulse
m  output  CHANNELS*M_WIDTH  active tuning words; channel c is m[c*M_WIDTH +: M_WIDTH]
set  output  CHANNELS  per-channel one-cycle strobe marking that m[c] was just updated
en  output  CHANNELS  per-channel output enable
err  output  1  one-cycle pulse when a byte is rejected

Behaviour:
- Reset (rst=1 at a clk edge): m, shadow words, set, en, transmit, tx_byte, err, sel all cleared to 0. Rx FSM goes to CMD. Tx FSM goes to TX_IDLE. Any readback in progress is aborted. rst takes priority over received on the same edge.
- Command byte is rx_byte = {op[3:0], arg[3:0]}. Internal sel is the selected channel; shadow[c] is an M_WIDTH-bit staging register per channel.
- Rx FSM, CMD state, on received, decodes op:
  - 0x1 WRITE(k): if k<NBYTES, latch k and go to DATA; else pulse err and stay in CMD.
  - 0x2 SELECT(c): if c<CHANNELS, sel<=c; else pulse err and leave sel unchanged.
  - 0x3 SET: m[sel]<=shadow[sel]; set[sel]=1 for exactly one cycle.
  - 0x4 ENABLE: en[sel]<=arg[0]. Other en bits are unchanged.
  - 0x5 READ: if the tx FSM is in TX_IDLE, snapshot m[sel] into the tx shift register and start readback; else pulse err.
  - 0x6 SET_ALL: all m[c]<=shadow[c] on the same edge; all set bits pulse together for one cycle.
  - Any other op: pulse err.
- Rx FSM, DATA state: the next received byte goes to shadow[sel][8k+7:8k] regardless of its value; return to CMD.
- No timeout in DATA. Only rst or a data byte leaves DATA.
- Latency: set, m, en, sel and err all change on the clk edge where received=1 is sampled. set and err are therefore high during the following cycle only.
- Writing shadow never disturbs m. The DDS sees a new word only through SET or SET_ALL, so partial words never glitch the output.
- Tx FSM states and transitions:
  - TX_IDLE -> TX_SEND when readback starts.
  - TX_SEND: when tx_busy=0, drive tx_byte = the next byte (LSB first), pulse transmit for one cycle, go to TX_GUARD.
  - TX_GUARD: one cycle in which tx_busy is ignored (UART start latency), then go to TX_WAIT.
  - TX_WAIT: when tx_busy=0, go to TX_SEND if bytes remain, else TX_IDLE.
  - Exactly NBYTES transmit pulses are issued per READ.
- The rx FSM keeps decoding during readback. WRITE, SET and ENABLE act normally. The snapshot already taken is not affected, so readback returns the value m had when READ was decoded.
- A received pulse on the same cycle that the tx FSM returns to TX_IDLE carrying READ: the tx FSM is still busy, so err pulses.

Test Plan:
- Reset, then no stimulus -> m=0, en=0, set=0, transmit=0, err=0 for 100 cycles.
- Bytes 0x20,0x10,0x2A,0x11,0x67,0x12,0x02,0x13,0x00 -> m[0] remains 0 throughout. Then 0x30 -> m[0]=157482 (0x0002672A), set=2'b01 for one cycle, m[1]=0.
- 0x21, write 0x00010000 via 0x10..0x13, 0x30, then 0x41 -> set=2'b10, en=2'b10. Then 0x40 -> en=2'b00 and m[1] unchanged.
- Load shadow0=0x11111111 and shadow1=0x22222222, then 0x60 -> both words update on one edge and set=2'b11 for one cycle.
- m[1]=0x0002672A with sel=1, then 0x50 under a tx_busy model (busy 10 cycles after each transmit) -> transmit pulses carry 0x2A,0x67,0x02,0x00 in that order, never while tx_busy=1. A second 0x50 sent mid-readback -> err pulse, stream unaffected. 0x30 sent mid-readback with a new shadow -> remaining bytes still from the snapshot.
- Errors: 0x14, then 0x22, then 0xF0 -> three err pulses, sel stays 1. The byte following 0x14 is treated as a command. Assert rst while in DATA and mid-readback -> next transmit=0, FSMs idle, and 0x30 then sets m[0]=0.
